// File: rtl/led_refresh_scheduler_pkg.sv
// Shared types and constants for the LED refresh scheduler.
//   sched_state_t  : scheduler FSM state (also exported on the debug port)
//   HANDOFF_CYCLES : lock-free cycles after each refresh pulse
//   GAP_W          : width of the handoff cycle counter
package led_refresh_scheduler_defs;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      HANDOFF = 2'd2
   } sched_state_t;

   localparam int unsigned HANDOFF_CYCLES = 2;
   localparam int unsigned GAP_W          = $clog2(HANDOFF_CYCLES + 1);

endpackage

// File: rtl/led_refresh_scheduler_if.sv
// Requester / strip-controller side bundle of the LED refresh scheduler.
//   req          : level requests, one per requester (driven by master)
//   grant        : one-hot or zero write grant
//   refresh_lock : high while any grant is active
//   refresh      : one-cycle frame request to the strip controller
//   hold_timeout : one-cycle pulse on a forced revoke
//   timeout_id   : index of the last revoked requester
// Handshake: req[i] is a level "valid"; grant[i] is the "ready" answer.
// A requester may write cells only in cycles where grant[i]==1, and ends
// its transaction by dropping req[i]; the grant falls one cycle later.
interface led_refresh_scheduler_if #(
   parameter int unsigned NUM_REQ = 4
);
   localparam int unsigned IW = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0] req;
   logic [NUM_REQ-1:0] grant;
   logic               refresh_lock;
   logic               refresh;
   logic               hold_timeout;
   logic [IW-1:0]      timeout_id;

   modport master (
      output req,
      input  grant, refresh_lock, refresh, hold_timeout, timeout_id
   );

   modport slave (
      input  req,
      output grant, refresh_lock, refresh, hold_timeout, timeout_id
   );
endinterface

// File: rtl/led_refresh_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
//   eligible : candidate requesters
//   last     : index of the previous winner; search starts just above it
//   onehot   : winner as a one-hot vector (zero when nothing eligible)
//   index    : winner index (zero when nothing eligible)
//   any      : at least one requester eligible
// Rotate so that last+1 lands on bit 0, take the lowest set bit, then
// rotate the position back into absolute index space.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic [N-1:0]         eligible,
   input  logic [$clog2(N)-1:0] last,
   output logic [N-1:0]         onehot,
   output logic [$clog2(N)-1:0] index,
   output logic                 any
);
   localparam int IW = $clog2(N);

   logic [2*N-1:0] dbl;
   logic [N-1:0]   rot;
   int             start_i;
   int             pos_i;
   int             idx_i;

   always_comb begin
      start_i = (int'(last) + 1) % N;
      dbl     = {eligible, eligible} >> start_i;
      rot     = dbl[N-1:0];
      pos_i   = 0;
      // Descending scan so the lowest set bit is the one left in pos_i.
      for (int i = N - 1; i >= 0; i--) begin
         if (rot[i]) pos_i = i;
      end
      idx_i  = (pos_i + start_i) % N;
      any    = |eligible;
      index  = any ? IW'(idx_i) : '0;
      onehot = any ? (N'(1) << idx_i) : '0;
   end
endmodule

// File: rtl/led_refresh_scheduler.sv
// Arbitrates write access to the LED cell array between NUM_REQ requesters
// and schedules refresh pulses to the LED strip controller: frames are
// rate-limited, forced after a keep-alive interval, and grants held too
// long are revoked.
//   clk       : system clock
//   rst       : synchronous reset, active low
//   bus       : requester/strip-controller bundle (slave side)
//   state_dbg : current scheduler state
module led_refresh_scheduler
   import led_refresh_scheduler_defs::*;
#(
   parameter int unsigned NUM_REQ          = 4,
   parameter int unsigned MIN_FRAME_CYCLES = 50000,
   parameter int unsigned KEEPALIVE_CYCLES = 5000000,
   parameter int unsigned MAX_HOLD_CYCLES  = 1024
) (
   input  logic                     clk,
   input  logic                     rst,
   led_refresh_scheduler_if.slave   bus,
   output sched_state_t             state_dbg
);
   localparam int unsigned IW   = $clog2(NUM_REQ);
   localparam int unsigned FMAX = (MIN_FRAME_CYCLES > KEEPALIVE_CYCLES) ?
                                  MIN_FRAME_CYCLES : KEEPALIVE_CYCLES;
   localparam int unsigned FW   = $clog2(FMAX) + 1;
   localparam int unsigned HW   = $clog2(MAX_HOLD_CYCLES) + 1;

   localparam logic [FW-1:0] MIN_F     = FW'(MIN_FRAME_CYCLES);
   localparam logic [FW-1:0] KEEP_F    = FW'(KEEPALIVE_CYCLES);
   localparam logic [FW-1:0] FMAX_F    = FW'(FMAX);
   localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD_CYCLES - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(HANDOFF_CYCLES);

   sched_state_t       state, state_next;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic               lock_q, lock_d;
   logic               refresh_q, refresh_d;
   logic               timeout_q, timeout_d;
   logic [IW-1:0]      tid_q, tid_d;
   logic               dirty_q, dirty_d;
   logic [IW-1:0]      last_q, last_d;
   logic [FW-1:0]      frame_q, frame_d;
   logic [HW-1:0]      hold_q, hold_d;
   logic [GAP_W-1:0]   gap_q, gap_d;
   logic [NUM_REQ-1:0] blocked_q, blocked_d;

   logic [NUM_REQ-1:0] eligible;
   logic [NUM_REQ-1:0] arb_onehot;
   logic [IW-1:0]      arb_index;
   logic               arb_any;
   logic               refresh_due;
   logic               owner_req;
   logic               at_limit;

   assign eligible    = bus.req & ~blocked_q;
   assign refresh_due = (dirty_q && (frame_q >= MIN_F)) ||
                        ((KEEPALIVE_CYCLES != 0) && (frame_q >= KEEP_F));
   // In GRANT, last_q is the index of the current owner.
   assign owner_req   = bus.req[last_q];
   assign at_limit    = (hold_q == HOLD_LAST);

   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .eligible (eligible),
      .last     (last_q),
      .onehot   (arb_onehot),
      .index    (arb_index),
      .any      (arb_any)
   );

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         grant_q   <= '0;
         lock_q    <= 1'b0;
         refresh_q <= 1'b0;
         timeout_q <= 1'b0;
         tid_q     <= '0;
         dirty_q   <= 1'b0;
         last_q    <= IW'(NUM_REQ - 1);
         frame_q   <= '0;
         hold_q    <= '0;
         gap_q     <= '0;
         blocked_q <= '0;
      end else begin
         state     <= state_next;
         grant_q   <= grant_d;
         lock_q    <= lock_d;
         refresh_q <= refresh_d;
         timeout_q <= timeout_d;
         tid_q     <= tid_d;
         dirty_q   <= dirty_d;
         last_q    <= last_d;
         frame_q   <= frame_d;
         hold_q    <= hold_d;
         gap_q     <= gap_d;
         blocked_q <= blocked_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: begin
            if (refresh_due)  state_next = HANDOFF;
            else if (arb_any) state_next = GRANT;
         end
         GRANT: begin
            if (!owner_req || at_limit) state_next = IDLE;
         end
         HANDOFF: begin
            if (gap_q == GAP_LAST) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Output and datapath next values.
   always_comb begin
      grant_d   = grant_q;
      lock_d    = lock_q;
      refresh_d = 1'b0;
      timeout_d = 1'b0;
      tid_d     = tid_q;
      dirty_d   = dirty_q;
      last_d    = last_q;
      hold_d    = hold_q;
      gap_d     = gap_q;
      frame_d   = (frame_q == FMAX_F) ? frame_q : frame_q + FW'(1);
      // A dropped request always re-arms a previously revoked requester.
      blocked_d = blocked_q & bus.req;
      unique case (state)
         IDLE: begin
            // Refresh wins over new grants so a due frame is never starved.
            if (refresh_due) begin
               refresh_d = 1'b1;
               dirty_d   = 1'b0;
               gap_d     = GAP_W'(1);
               frame_d   = '0;
            end else if (arb_any) begin
               grant_d = arb_onehot;
               lock_d  = 1'b1;
               last_d  = arb_index;
               hold_d  = '0;
            end
         end
         GRANT: begin
            hold_d = hold_q + HW'(1);
            if (!owner_req || at_limit) begin
               grant_d = '0;
               lock_d  = 1'b0;
               dirty_d = 1'b1;
               if (owner_req) begin
                  timeout_d = 1'b1;
                  tid_d     = last_q;
                  blocked_d = blocked_d | grant_q;
               end
            end
         end
         HANDOFF: begin
            gap_d = gap_q + GAP_W'(1);
         end
         default: ;
      endcase
   end

   assign bus.grant        = grant_q;
   assign bus.refresh_lock = lock_q;
   assign bus.refresh      = refresh_q;
   assign bus.hold_timeout = timeout_q;
   assign bus.timeout_id   = tid_q;
   assign state_dbg        = state;

endmodule

// File: tb/tb_led_refresh_scheduler.sv
// Testbench for led_refresh_scheduler with NUM_REQ=3, MIN_FRAME_CYCLES=20,
// KEEPALIVE_CYCLES=100, MAX_HOLD_CYCLES=8. A transaction-level reference
// model tracks owner, cycles held, cycles since the last frame and the
// pending-frame flag, and predicts every output each cycle.
module tb_led_refresh_scheduler;
   import led_refresh_scheduler_defs::*;

   localparam int N    = 3;
   localparam int MINF = 20;
   localparam int KEEP = 100;
   localparam int MAXH = 8;
   localparam int SAT  = (MINF > KEEP) ? MINF : KEEP;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   led_refresh_scheduler_if #(.NUM_REQ(N)) bus ();
   sched_state_t state_dbg;

   led_refresh_scheduler #(
      .NUM_REQ          (N),
      .MIN_FRAME_CYCLES (MINF),
      .KEEPALIVE_CYCLES (KEEP),
      .MAX_HOLD_CYCLES  (MAXH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   int tests = 0;
   int fails = 0;

   // ---------------- reference model ----------------
   int m_owner;   // -1 when nobody holds the grant
   int m_held;    // cycles the owner has held the grant, counting this one
   int m_since;   // cycles since the last frame, saturating
   int m_pause;   // lock-free cycles left after a refresh
   int m_last;
   int m_tid;
   bit m_dirty;
   bit m_ref;
   bit m_to;
   bit m_blocked[N];

   task automatic model_reset();
      m_owner = -1; m_held = 0; m_since = 0; m_pause = 0;
      m_last = N - 1; m_tid = 0; m_dirty = 0; m_ref = 0; m_to = 0;
      for (int i = 0; i < N; i++) m_blocked[i] = 0;
   endtask

   // Called at each rising edge with the inputs that edge samples.
   task automatic model_step();
      logic [N-1:0] rq;
      bit nb[N];
      int since_new;
      bit found;
      rq = bus.req;
      if (rst !== 1'b1) begin
         model_reset();
         return;
      end
      for (int i = 0; i < N; i++) nb[i] = m_blocked[i] && rq[i];
      since_new = (m_since < SAT) ? m_since + 1 : SAT;
      m_ref = 0;
      m_to  = 0;
      if (m_pause > 0) begin
         m_pause--;
      end else if (m_owner >= 0) begin
         if (!rq[m_owner] || m_held == MAXH) begin
            if (rq[m_owner]) begin
               m_to = 1;
               m_tid = m_owner;
               nb[m_owner] = 1;
            end
            m_owner = -1;
            m_dirty = 1;
         end else begin
            m_held++;
         end
      end else if ((m_dirty && m_since >= MINF) || m_since >= KEEP) begin
         m_ref = 1;
         m_dirty = 0;
         since_new = 0;
         m_pause = HANDOFF_CYCLES;
      end else begin
         found = 0;
         for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_last + k) % N;
            if (!found && rq[c] && !m_blocked[c]) begin
               found = 1;
               m_owner = c;
               m_last = c;
               m_held = 1;
            end
         end
      end
      m_since = since_new;
      for (int i = 0; i < N; i++) m_blocked[i] = nb[i];
   endtask

   // ---------------- scoreboard ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      logic [31:0] e_grant;
      sched_state_t e_state;
      e_grant = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
      e_state = (m_owner >= 0) ? GRANT : ((m_pause > 0) ? HANDOFF : IDLE);
      chk("grant",        32'(bus.grant),        e_grant);
      chk("refresh_lock", 32'(bus.refresh_lock), 32'(m_owner >= 0));
      chk("refresh",      32'(bus.refresh),      32'(m_ref));
      chk("hold_timeout", 32'(bus.hold_timeout), 32'(m_to));
      chk("timeout_id",   32'(bus.timeout_id),   32'(m_tid));
      chk("state",        32'(state_dbg),        32'(e_state));
   endtask

   // ---------------- driver ----------------
   task automatic step();
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Steps until a refresh pulse is seen; returns the number of steps.
   task automatic wait_refresh(input int limit, output int cnt);
      cnt = 0;
      for (int i = 0; i < limit; i++) begin
         step();
         cnt++;
         if (bus.refresh === 1'b1) break;
      end
      if (bus.refresh !== 1'b1) chk("refresh_wait_bound", 32'(bus.refresh), 32'd1);
   endtask

   task automatic wait_owner(input int who, input int limit);
      for (int i = 0; i < limit; i++) begin
         if (m_owner == who) break;
         step();
      end
      chk("owner_wait_bound", 32'(bus.grant), 32'd1 << who);
   endtask

   initial begin
      int cnt;
      int pulses;
      int to0;

      // 1. reset, then keep-alive from an idle bus
      model_reset();
      rst = 1'b0;
      bus.req = '0;
      run(3);
      rst = 1'b1;
      // frame count reaches KEEP on the KEEP-th edge; the pulse registers on the next.
      wait_refresh(KEEP + 10, cnt);
      chk("keepalive_after_reset", 32'(cnt), 32'(KEEP + 1));
      run(4);

      // 2. all three requesting; each drops after 3 granted cycles and re-raises
      for (int c = 0; c < 45; c++) begin
         for (int i = 0; i < N; i++) bus.req[i] = !(m_owner == i && m_held >= 3);
         step();
      end
      bus.req = '0;
      run(25);

      // 3. two short grants right after a frame coalesce into one deferred pulse
      wait_refresh(KEEP + 10, cnt);
      run(5);
      bus.req = 3'b100;
      run(4);
      bus.req = 3'b001;
      run(4);
      bus.req = 3'b000;
      pulses = 0;
      for (int i = 0; i < 30; i++) begin
         step();
         if (bus.refresh === 1'b1) pulses++;
      end
      chk("coalesced_pulses", 32'(pulses), 32'd1);

      // 4. requester 0 overstays; requester 1 joins meanwhile
      to0 = 0;
      bus.req = 3'b001;
      for (int i = 0; i < 20; i++) begin
         if (i == 5) bus.req[1] = 1'b1;
         if (m_owner == 1 && m_held >= 2) bus.req[1] = 1'b0;
         step();
         if (bus.hold_timeout === 1'b1 && bus.timeout_id === 2'd0) to0++;
      end
      chk("revokes_of_req0", 32'(to0), 32'd1);
      bus.req = '0;
      run(12);

      // 5. random request traffic
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < N; i++)
            if ($urandom_range(7) == 0) bus.req[i] = ~bus.req[i];
         step();
      end
      bus.req = '0;
      run(12);

      // 6. reset while requester 2 holds the grant with a frame pending
      wait_refresh(KEEP + 10, cnt);
      bus.req = 3'b001;
      wait_owner(0, 10);
      step();
      bus.req = 3'b100;
      wait_owner(2, 10);
      rst = 1'b0;
      step();
      rst = 1'b1;
      bus.req = '0;
      wait_refresh(KEEP + 10, cnt);
      chk("no_refresh_before_keepalive", 32'(cnt), 32'(KEEP + 1));
      run(5);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
